// File: rtl/ram_stream_reader_if.sv
// Signal bundle for ram_stream_reader: burst control, RAM read port and output stream.
// The master modport is the reader; the slave modport is its surroundings.
interface ram_stream_reader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 17
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  length;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  start, base_addr, length, ram_rdata, m_ready,
    output busy, done, ram_addr, m_data, m_valid
  );

  modport slave (
    output start, base_addr, length, ram_rdata, m_ready,
    input  busy, done, ram_addr, m_data, m_valid
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Burst reader for a 1-cycle-latency RAM read port, streaming words out on valid/ready.
// A 2-entry output buffer plus an in-flight flag hides RAM latency under backpressure.
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 17
) (
  input logic                clk,
  input logic                rst,
  ram_stream_reader_if.master bus
);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t                state;
  logic                  busy_r;
  logic                  done_r;
  logic                  valid_p2;
  logic [1:0]            occ;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [LEN_WIDTH-1:0]  to_issue;
  logic [LEN_WIDTH-1:0]  beats_left;
  logic [DATA_WIDTH-1:0] head_p2;
  logic [DATA_WIDTH-1:0] skid_p2;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [1:0]            occ_next;

  // A new read fits only if buffered + in-flight words, less the one leaving now, stay below 2.
  function automatic logic has_room(input logic [1:0] o, input logic f, input logic p);
    return ({1'b0, o} + {2'b00, f}) < (3'd2 + {2'b00, p});
  endfunction

  always_comb begin
    pop      = valid_p2 & bus.m_ready;
    push     = vld_p1;
    issue    = (state == RUN) && (to_issue != '0) && has_room(occ, vld_p1, pop);
    occ_next = occ + {1'b0, push} - {1'b0, pop};
  end

  // Stage p0: address issue and burst control; p1: RAM read in flight; p2: output buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      valid_p2   <= 1'b0;
      occ        <= 2'd0;
      vld_p1     <= 1'b0;
      addr_p0    <= '0;
      to_issue   <= '0;
      beats_left <= '0;
      head_p2    <= '0;
    end else begin
      done_r   <= 1'b0;
      vld_p1   <= issue;
      occ      <= occ_next;
      valid_p2 <= (occ_next != 2'd0);

      if (issue) begin
        addr_p0  <= addr_p0 + ADDR_WIDTH'(1);
        to_issue <= to_issue - LEN_WIDTH'(1);
      end

      if (push && (occ == 2'd0 || (occ == 2'd1 && pop)))
        head_p2 <= bus.ram_rdata;
      else if (pop && occ == 2'd2)
        head_p2 <= skid_p2;

      case (state)
        IDLE: begin
          if (bus.start) begin
            addr_p0 <= bus.base_addr;
            if (bus.length != '0) begin
              state      <= RUN;
              busy_r     <= 1'b1;
              to_issue   <= bus.length;
              beats_left <= bus.length;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pop) begin
            beats_left <= beats_left - LEN_WIDTH'(1);
            if (beats_left == LEN_WIDTH'(1)) begin
              state  <= IDLE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Second buffer slot holds data only; its contents are meaningless unless occ says otherwise.
  always_ff @(posedge clk) begin
    if (push && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop)))
      skid_p2 <= bus.ram_rdata;
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.ram_addr = addr_p0;
  assign bus.m_data   = head_p2;
  assign bus.m_valid  = valid_p2;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader with a behavioural 1-cycle-latency RAM.
module tb_ram_stream_reader;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int LW    = 17;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) bus.ram_rdata <= mem[bus.ram_addr];

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q [$];
  int            acc_cnt = 0;
  int            done_cnt = 0;
  int            ready_mode = 0;
  logic [AW-1:0] cur_base = '0;
  logic [AW-1:0] issued_m;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer side: scoreboard pop, hold-while-stalled and outstanding-read bound.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.done) done_cnt++;
      if (prev_stall) begin
        check_val("hold_valid", bus.m_valid, 1);
        check_val("hold_data", bus.m_data, prev_data);
      end
      if (bus.busy) begin
        issued_m = bus.ram_addr - cur_base;
        check_val("outstanding_le2", ((int'(issued_m) - acc_cnt) <= 2), 1);
      end
      if (bus.m_valid && bus.m_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) check_val("sb_underflow", bus.m_valid, 0);
        else check_val("beat", bus.m_data, exp_q.pop_front());
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input logic [LW-1:0] l, input bit track);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = b;
    bus.length    = l;
    if (track) begin
      cur_base = b;
      acc_cnt  = 0;
      for (int i = 0; i < int'(l); i++) exp_q.push_back(mem[AW'(int'(b) + i)]);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cycles && !seen; k++) begin
      @(negedge clk);
      seen = bus.done;
    end
    check_val("done_seen", seen, 1);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 3);
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    rst           = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_valid", bus.m_valid, 0);
    check_val("rst_data", bus.m_data, 0);
    check_val("rst_addr", bus.ram_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full-rate burst: first beat two edges after start, then no bubbles.
    do_start(16'h0010, 8, 1);
    @(negedge clk) check_val("lat_e0_valid", bus.m_valid, 0);
    check_val("lat_e0_busy", bus.busy, 1);
    @(negedge clk) check_val("lat_e1_valid", bus.m_valid, 0);
    @(negedge clk) check_val("lat_e2_valid", bus.m_valid, 1);
    repeat (7) begin
      @(negedge clk) check_val("no_bubble", bus.m_valid, 1);
    end
    @(negedge clk);
    check_val("done_after_last", bus.done, 1);
    check_val("busy_after_last", bus.busy, 0);
    check_val("valid_after_last", bus.m_valid, 0);
    @(negedge clk) check_val("done_one_cycle", bus.done, 0);
    check_val("sb_empty_full", exp_q.size(), 0);

    // Same burst under random backpressure.
    ready_mode = 1;
    d0 = done_cnt;
    do_start(16'h0010, 8, 1);
    wait_done(300);
    repeat (4) @(negedge clk);
    check_val("done_once_rand", done_cnt - d0, 1);
    check_val("sb_empty_rand", exp_q.size(), 0);
    ready_mode = 0;

    // Address wrap.
    do_start(16'hFFFE, 4, 1);
    wait_done(50);
    repeat (2) @(negedge clk);
    check_val("sb_empty_wrap", exp_q.size(), 0);

    // Zero-length request.
    d0 = done_cnt;
    do_start(16'h0030, 0, 0);
    @(negedge clk);
    check_val("len0_done", bus.done, 1);
    check_val("len0_busy", bus.busy, 0);
    check_val("len0_valid", bus.m_valid, 0);
    @(negedge clk);
    check_val("len0_done_drop", bus.done, 0);
    check_val("len0_valid2", bus.m_valid, 0);
    check_val("len0_done_cnt", done_cnt - d0, 1);

    // Start while busy must be ignored.
    ready_mode = 1;
    d0 = done_cnt;
    do_start(16'h0020, 8, 1);
    repeat (3) @(posedge clk);
    do_start(16'h0040, 3, 0);
    wait_done(300);
    repeat (6) @(negedge clk);
    check_val("ignored_start_done", done_cnt - d0, 1);
    check_val("ignored_start_busy", bus.busy, 0);
    check_val("sb_empty_ignored", exp_q.size(), 0);
    ready_mode = 0;

    // Asynchronous reset mid-burst, then a clean burst.
    do_start(16'h0010, 8, 1);
    for (int k = 0; k < 50 && acc_cnt < 3; k++) @(negedge clk);
    check_val("mid_beats_reached", (acc_cnt >= 3), 1);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_valid", bus.m_valid, 0);
    check_val("mid_rst_busy", bus.busy, 0);
    check_val("mid_rst_data", bus.m_data, 0);
    check_val("mid_rst_addr", bus.ram_addr, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    do_start(16'h0050, 5, 1);
    wait_done(50);
    repeat (2) @(negedge clk);
    check_val("sb_empty_after_rst", exp_q.size(), 0);
    check_val("beats_after_rst", acc_cnt, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_err);
    $fatal(1);
  end

endmodule
